spring_plunger_ctrl: RTL and testbench
======================================

# spring_plunger_ctrl

Plunger-side controller for the pinball spring. It turns the player's pull key into a per-frame spring compression and drives the geometry of the spring rectangle that the spring bitmap draws. It consumes the drawn spring pixels (`drawSpring`) together with the ball pixels to detect spring/ball contact during release. On contact it emits a one-cycle launch pulse with an upward speed proportional to the pull strength.

## Interface
Parameters:
- `SPRING_BASE_Y`, 460: screen Y of the spring's fixed bottom edge.
- `REST_HEIGHT`, 64: spring height in pixels when uncompressed.
- `MAX_COMPRESSION`, 48: compression saturation limit in pixels; must be less than `REST_HEIGHT`.
- `PULL_STEP`, 1: compression added per frame while pulling.
- `RELEASE_STEP`, 8: compression removed per frame while releasing.
- `SPEED_SHIFT`, 3: launch speed equals latched compression shifted left by this amount.
- `MAX_SPEED`, 320: launch speed magnitude clamp.
- `COOLDOWN_FRAMES`, 30: frames spent in COOLDOWN.
- `AUTO_RELEASE_FRAMES`, 120: see Configuration.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `startOfFrame`, in, 1: one-cycle pulse, once per video frame.
- `keyPull`, in, 1: pull key level, 1 = held.
- `drawSpring`, in, 1: spring bitmap is drawing the current pixel.
- `drawBall`, in, 1: ball bitmap is drawing the current pixel.
- `springTopY`, out, 11: top Y of the spring rectangle.
- `springHeight`, out, 11: spring rectangle height.
- `launch`, out, 1: one-cycle launch pulse.
- `launchSpeedY`, out, 11: two's-complement Y speed, negative = up; held until the next launch.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Internal state: `comp` (compression, 0..`MAX_COMPRESSION`), `latched`, `launched` flag, frame counter.
- Geometry is always derived from `comp`:
  - `springHeight = REST_HEIGHT - comp`.
  - `springTopY = SPRING_BASE_Y - REST_HEIGHT + comp`.
- State transitions are evaluated only on `startOfFrame` cycles, except the contact check.
- IDLE: `comp = 0`. On `startOfFrame` with `keyPull = 1`, go to PULLING.
- PULLING, on each `startOfFrame`:
  - If `keyPull = 1`: `comp = min(comp + PULL_STEP, MAX_COMPRESSION)`.
  - If `keyPull = 0`: `latched = comp`, clear `launched`, go to RELEASING. `comp` is not changed on this frame.
- RELEASING:
  - On each `startOfFrame`: `comp = max(comp - RELEASE_STEP, 0)`, with no unsigned underflow.
  - When `comp` becomes 0, go to COOLDOWN and load the frame counter with `COOLDOWN_FRAMES`.
  - On any cycle where `drawSpring & drawBall & !launched`: set `launched` and pulse `launch`.
  - Launch speed: `launchSpeedY = -min(latched << SPEED_SHIFT, MAX_SPEED)`.
  - At most one launch per release. If no contact occurs before COOLDOWN, no launch is issued.
- COOLDOWN:
  - Decrement the frame counter on each `startOfFrame`; at 0, go to IDLE.
  - `keyPull` and contact are ignored.
- Contact in IDLE, PULLING or COOLDOWN never launches (the ball is resting on the spring).
- A `startOfFrame` and a contact in the same cycle are both processed. The launch uses `latched`, which is unaffected by the `comp` update in that cycle.
- Releasing with `latched = 0` still passes through RELEASING for one frame. Contact then gives `launchSpeedY = 0` with the `launch` pulse still issued.

## Timing
- All outputs are registered.
- Geometry outputs change on the cycle after the `startOfFrame` that updates `comp`.
- `launch` is high for exactly the one cycle following the contact cycle. `launchSpeedY` is valid in the same cycle as `launch`.
- `reset` asserted at any time, including mid-release, forces on the next edge or asynchronously:
  - IDLE.
  - `comp = latched = 0`.
  - `launched = 0`.
  - `springTopY = SPRING_BASE_Y - REST_HEIGHT`, `springHeight = REST_HEIGHT`.
  - `launch = 0`, `launchSpeedY = 0`, `busy = 0`.
- After `reset` deasserts, the first action is possible on the first `startOfFrame`.

## Configuration
- `SPRING_AUTO_RELEASE_EN` defined:
  - In PULLING, count consecutive frames with `comp == MAX_COMPRESSION`.
  - When the count reaches `AUTO_RELEASE_FRAMES`, go to RELEASING exactly as if `keyPull` had dropped, even while the key is held.
  - After COOLDOWN, a still-held key re-enters PULLING.
- `SPRING_AUTO_RELEASE_EN` not defined: the spring is held at maximum compression indefinitely; the counter logic is absent.

## Test plan
- Reset mid-RELEASING with `comp = 24` -> outputs immediately `springTopY = 396`, `springHeight = 64`, `launch = 0`, `busy = 0`.
- Hold `keyPull` for 10 frames, release, assert `drawSpring = drawBall = 1` during the next release frame:
  - `comp` reaches 10.
  - One `launch` pulse with `launchSpeedY = -80` (11'h7B0).
- Hold `keyPull` for 100 frames:
  - `comp` saturates at 48, `springHeight = 16`.
  - On release and contact, `launchSpeedY = -320` (clamped from 384).
- Release with no contact:
  - `comp` steps 48 -> 40 -> ... -> 0.
  - No `launch`.
  - `busy` stays high for 30 further frames, then IDLE.
- Continuous contact throughout RELEASING -> exactly one `launch` pulse. Contact during PULLING or COOLDOWN -> none.
- With `SPRING_AUTO_RELEASE_EN`, key held continuously:
  - Forced release 120 frames after `comp` first reaches 48.
  - Without the macro, there is no release while the key is held.

Source files
------------

// File: rtl/spring_plunger_ctrl.sv
// Pinball plunger controller: pull-key compression, spring geometry and contact launch.
// Optional SPRING_AUTO_RELEASE_EN forces a release after a hold at full compression.
module spring_plunger_ctrl #(
    parameter int SPRING_BASE_Y       = 460,
    parameter int REST_HEIGHT         = 64,
    parameter int MAX_COMPRESSION     = 48,
    parameter int PULL_STEP           = 1,
    parameter int RELEASE_STEP        = 8,
    parameter int SPEED_SHIFT         = 3,
    parameter int MAX_SPEED           = 320,
    parameter int COOLDOWN_FRAMES     = 30,
    parameter int AUTO_RELEASE_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        keyPull,
    input  logic        drawSpring,
    input  logic        drawBall,
    output logic [10:0] springTopY,
    output logic [10:0] springHeight,
    output logic        launch,
    output logic [10:0] launchSpeedY,
    output logic        busy
);

    localparam logic [10:0] TOP_REST  = 11'(SPRING_BASE_Y - REST_HEIGHT);
    localparam logic [10:0] H_REST    = 11'(REST_HEIGHT);
    localparam logic [10:0] COMP_MAX  = 11'(MAX_COMPRESSION);
    localparam logic [10:0] STEP_PULL = 11'(PULL_STEP);
    localparam logic [10:0] STEP_REL  = 11'(RELEASE_STEP);
    localparam logic [10:0] CD_LOAD   = 11'(COOLDOWN_FRAMES);
    localparam logic [31:0] SPEED_LIM = 32'(MAX_SPEED);

    typedef enum logic [1:0] {
        IDLE,
        PULLING,
        RELEASING,
        COOLDOWN
    } state_t;

    state_t      state, state_n;
    logic [10:0] comp, comp_n;
    logic [10:0] latched, latched_n;
    logic        launched, launched_n;
    logic [10:0] cd_cnt, cd_cnt_n;
    logic [10:0] speed_n;
    logic        launch_n;
    logic        contact;
    logic        auto_hit;
    logic [31:0] speed_raw;
    logic [31:0] speed_mag;

    assign contact = drawSpring & drawBall;

    // Speed magnitude depends only on latched, so a comp update in the same cycle cannot affect it.
    always_comb begin
        speed_raw = 32'(latched) << SPEED_SHIFT;
        speed_mag = (speed_raw > SPEED_LIM) ? SPEED_LIM : speed_raw;
    end

`ifdef SPRING_AUTO_RELEASE_EN
    logic [31:0] hold_cnt, hold_cnt_n;

    assign auto_hit = keyPull && (comp == COMP_MAX) &&
                      (hold_cnt + 32'd1 >= 32'(AUTO_RELEASE_FRAMES));

    always_comb begin
        hold_cnt_n = hold_cnt;
        if (state != PULLING) begin
            hold_cnt_n = '0;
        end else if (startOfFrame) begin
            if (keyPull && comp == COMP_MAX) begin
                hold_cnt_n = hold_cnt + 32'd1;
            end else begin
                hold_cnt_n = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_n;
        end
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        comp_n     = comp;
        latched_n  = latched;
        launched_n = launched;
        cd_cnt_n   = cd_cnt;
        launch_n   = 1'b0;
        speed_n    = launchSpeedY;

        case (state)
            IDLE: begin
                comp_n = '0;
                if (startOfFrame && keyPull) begin
                    state_n = PULLING;
                end
            end

            PULLING: begin
                if (startOfFrame) begin
                    if (!keyPull || auto_hit) begin
                        latched_n  = comp;
                        launched_n = 1'b0;
                        state_n    = RELEASING;
                    end else if (comp + STEP_PULL > COMP_MAX) begin
                        comp_n = COMP_MAX;
                    end else begin
                        comp_n = comp + STEP_PULL;
                    end
                end
            end

            RELEASING: begin
                if (startOfFrame) begin
                    if (comp <= STEP_REL) begin
                        comp_n   = '0;
                        cd_cnt_n = CD_LOAD;
                        state_n  = COOLDOWN;
                    end else begin
                        comp_n = comp - STEP_REL;
                    end
                end
                if (contact && !launched) begin
                    launched_n = 1'b1;
                    launch_n   = 1'b1;
                    speed_n    = 11'd0 - speed_mag[10:0];
                end
            end

            COOLDOWN: begin
                if (startOfFrame) begin
                    if (cd_cnt <= 11'd1) begin
                        cd_cnt_n = '0;
                        state_n  = IDLE;
                    end else begin
                        cd_cnt_n = cd_cnt - 11'd1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so geometry and busy track comp/state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            comp         <= '0;
            latched      <= '0;
            launched     <= 1'b0;
            cd_cnt       <= '0;
            springTopY   <= TOP_REST;
            springHeight <= H_REST;
            launch       <= 1'b0;
            launchSpeedY <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            comp         <= comp_n;
            latched      <= latched_n;
            launched     <= launched_n;
            cd_cnt       <= cd_cnt_n;
            springTopY   <= TOP_REST + comp_n;
            springHeight <= H_REST - comp_n;
            launch       <= launch_n;
            launchSpeedY <= speed_n;
            busy         <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_spring_plunger_ctrl.sv
// Directed bench for spring_plunger_ctrl; launch speeds are checked through a scoreboard queue.
// Define SPRING_AUTO_RELEASE_EN for both files to exercise the forced-release path.
module tb_spring_plunger_ctrl;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic        keyPull;
    logic        drawSpring;
    logic        drawBall;
    logic [10:0] springTopY;
    logic [10:0] springHeight;
    logic        launch;
    logic [10:0] launchSpeedY;
    logic        busy;

    int checks;
    int errors;
    logic [10:0] sb[$];

    spring_plunger_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .keyPull      (keyPull),
        .drawSpring   (drawSpring),
        .drawBall     (drawBall),
        .springTopY   (springTopY),
        .springHeight (springHeight),
        .launch       (launch),
        .launchSpeedY (launchSpeedY),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic sof();
        @(posedge clk); #1 startOfFrame = 1'b1;
        @(posedge clk); #1 startOfFrame = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic touch();
        @(posedge clk); #1 begin drawSpring = 1'b1; drawBall = 1'b1; end
        @(posedge clk); #1 begin drawSpring = 1'b0; drawBall = 1'b0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int frames);
        frames = 0;
        while (busy && frames < limit) begin
            sof();
            frames++;
        end
    endtask

    // Every launch pulse must match the next queued expectation; extra pulses find the queue empty.
    always @(negedge clk) begin
        if (!reset && launch === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_launch observed speed=0x%0h expected no launch", launchSpeedY);
            end
            if (sb.size() != 0) begin
                logic [10:0] exp;
                exp = sb.pop_front();
                assert (launchSpeedY === exp) else begin
                    errors++;
                    $error("FAIL launch_speed observed=0x%0h expected=0x%0h", launchSpeedY, exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [10:0] ec;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        startOfFrame = 1'b0;
        keyPull = 1'b0;
        drawSpring = 1'b0;
        drawBall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_top", springTopY, 11'd396);
        chk("rst_height", springHeight, 11'd64);
        chk("rst_launch", {10'd0, launch}, 11'd0);
        chk("rst_speed", launchSpeedY, 11'd0);
        chk("rst_busy", {10'd0, busy}, 11'd0);
        #1 reset = 1'b0;

        // A: enter pull plus 10 pull frames -> comp 10, contact -> -80
        keyPull = 1'b1;
        repeat (11) sof();
        chk("a_height", springHeight, 11'd54);
        chk("a_top", springTopY, 11'd406);
        chk("a_busy", {10'd0, busy}, 11'd1);
        keyPull = 1'b0;
        sof();
        chk("a_release_hold", springHeight, 11'd54);
        sb.push_back(11'h7B0);
        touch();
        wait_idle(60, n);
        chk("a_idle", {10'd0, busy}, 11'd0);
        chk("a_speed_held", launchSpeedY, 11'h7B0);
        chk("a_sb_drained", 11'(sb.size()), 11'd0);

        // B: saturate, contact during pull ignored, continuous contact -> one clamped launch
        keyPull = 1'b1;
        repeat (100) sof();
        chk("b_height", springHeight, 11'd16);
        chk("b_top", springTopY, 11'd444);
        touch();
        keyPull = 1'b0;
        sof();
        sb.push_back(11'h6C0);
        drawSpring = 1'b1;
        drawBall = 1'b1;
        repeat (8) sof();
        drawSpring = 1'b0;
        drawBall = 1'b0;
        chk("b_sb_drained", 11'(sb.size()), 11'd0);
        chk("b_speed", launchSpeedY, 11'h6C0);
        wait_idle(60, n);
        chk("b_idle", {10'd0, busy}, 11'd0);

        // C: release with no contact, step-down profile and cooldown length
        keyPull = 1'b1;
        repeat (100) sof();
        keyPull = 1'b0;
        sof();
        for (int k = 1; k <= 6; k++) begin
            sof();
            ec = 11'(48 - 8 * k);
            chk("c_step_height", springHeight, 11'd64 - ec);
            chk("c_step_top", springTopY, 11'd396 + ec);
        end
        touch();
        wait_idle(40, n);
        chk("c_cooldown_frames", 11'(n), 11'd30);
        chk("c_idle", {10'd0, busy}, 11'd0);

        // D: zero-compression release still launches with speed 0
        keyPull = 1'b1;
        sof();
        keyPull = 1'b0;
        sof();
        chk("d_busy_rel", {10'd0, busy}, 11'd1);
        sb.push_back(11'd0);
        touch();
        sof();
        chk("d_busy_cd", {10'd0, busy}, 11'd1);
        chk("d_speed", launchSpeedY, 11'd0);
        wait_idle(40, n);
        chk("d_cooldown_frames", 11'(n), 11'd30);

        // E: key held at full compression
        keyPull = 1'b1;
        repeat (49) sof();
        chk("e_full", springHeight, 11'd16);
        repeat (119) sof();
        chk("e_hold_119", springHeight, 11'd16);
        sof();
        chk("e_hold_120", springHeight, 11'd16);
        sof();
`ifdef SPRING_AUTO_RELEASE_EN
        chk("e_auto_released", springHeight, 11'd24);
        wait_idle(60, n);
        sof();
        chk("e_repull", {10'd0, busy}, 11'd1);
`else
        chk("e_no_auto", springHeight, 11'd16);
`endif
        keyPull = 1'b0;
        sof();
        wait_idle(60, n);
        chk("e_idle", {10'd0, busy}, 11'd0);

        // F: asynchronous reset mid-release at comp 24
        keyPull = 1'b1;
        repeat (25) sof();
        keyPull = 1'b0;
        sof();
        chk("f_height_pre", springHeight, 11'd40);
        chk("f_busy_pre", {10'd0, busy}, 11'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("f_top", springTopY, 11'd396);
        chk("f_height", springHeight, 11'd64);
        chk("f_launch", {10'd0, launch}, 11'd0);
        chk("f_speed", launchSpeedY, 11'd0);
        chk("f_busy", {10'd0, busy}, 11'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sof();
        chk("f_stay_idle", {10'd0, busy}, 11'd0);
        chk("f_sb_drained", 11'(sb.size()), 11'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
